output_port_ctrl: RTL and testbench
===================================

OUTPUT_PORT_CTRL -- requirements
Module: output_port_ctrl

Interface
REQ-001 Parameter NUM_IN, default 5, number of input units competing for this output port.
REQ-002 Parameter FLIT_W, default 34, flit width in bits.
REQ-003 Parameter CREDITS, default 4, downstream buffer depth in flits; CW = $clog2(CREDITS+1).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 i_req  input  NUM_IN  per-input switch request, held high by the input unit until granted.
REQ-007 o_grant  output  NUM_IN  one-hot owner of the port; all zero when free.
REQ-008 i_valid  input  NUM_IN  per-input flit valid.
REQ-009 i_tail  input  NUM_IN  per-input flit is last of packet; a head-tail flit sets it.
REQ-010 i_data  input  NUM_IN x FLIT_W  per-input flit payload.
REQ-011 o_ready  output  NUM_IN  per-input pop strobe; at most one bit high.
REQ-012 o_valid  output  1  registered flit valid to downstream link.
REQ-013 o_data  output  FLIT_W  registered flit payload.
REQ-014 o_tail  output  1  registered tail marker.
REQ-015 i_credit_return  input  1  one-cycle pulse; downstream freed one buffer slot.
REQ-016 o_credits  output  CW  current credit count.
REQ-017 o_port_status  output  1  0 = PORT_FREE, 1 = PORT_OCCUPIED.
REQ-018 o_state  output  2  current FSM state encoding.
REQ-019 o_credit_err  output  1  one-cycle pulse on credit overflow.

Function
REQ-020 States: IDLE, ACTIVE, BLOCKED; o_port_status = PORT_OCCUPIED in ACTIVE and BLOCKED.
REQ-021 IDLE: if any i_req high, round-robin arbiter selects owner; o_grant registered, state -> ACTIVE next cycle.
REQ-022 Round-robin: search starts at pointer ptr; after a grant to input k, ptr <= (k+1) mod NUM_IN.
REQ-023 fire = (state==ACTIVE) && i_valid[owner] && (o_credits != 0); o_ready[owner] = fire, combinational.
REQ-024 On fire: o_valid <= 1, o_data <= i_data[owner], o_tail <= i_tail[owner]; otherwise o_valid <= 0, o_data/o_tail hold; latency 1 cycle.
REQ-025 Credit arithmetic: fire only -> -1; i_credit_return only -> +1; both same cycle -> unchanged.
REQ-026 i_credit_return while o_credits == CREDITS and no fire -> count held, o_credit_err pulses 1 cycle.
REQ-027 ACTIVE -> BLOCKED when o_credits == 0; BLOCKED -> ACTIVE on i_credit_return; grant held throughout.
REQ-028 Fire with i_tail[owner] high -> state IDLE, o_grant cleared next cycle; a new arbitration occurs in IDLE (one bubble between packets).
REQ-029 Fire with last credit and tail in the same cycle -> IDLE takes priority over BLOCKED.
REQ-030 i_req of the owner is ignored while ACTIVE/BLOCKED; requests of others wait, not dropped.
REQ-031 Never more than one o_grant bit or one o_ready bit high; no fire in IDLE or BLOCKED.

Reset
REQ-032 On reset_n low: state IDLE, o_grant 0, ptr 0, o_credits = CREDITS, o_valid 0, o_data 0, o_tail 0, o_credit_err 0.
REQ-033 Reset mid-packet abandons the packet; no flit emitted until a fresh grant after reset release.

Structure
REQ-034 router_pkg holds the state enum (IDLE, ACTIVE, BLOCKED), PORT_STATUS_t and default FLIT_W; parameters stay local.
REQ-035 One sub-module rr_arbiter (parameter N): request vector, update enable -> one-hot grant, owns ptr.

Verification
REQ-036 Single input 2, 3-flit packet, credits 4 -> grant[2] next cycle, three o_valid beats 1 cycle after each o_ready, o_credits 4->1, IDLE after tail.
REQ-037 Inputs 0,1,3 request continuously, single-flit packets -> grants in order 0,1,3,0 with one IDLE bubble between each.
REQ-038 CREDITS=2, 5-flit packet, no returns -> 2 flits sent, BLOCKED, o_ready 0; one return pulse -> exactly one more flit, BLOCKED again.
REQ-039 Fire and i_credit_return same cycle at o_credits=1 -> o_credits stays 1, state stays ACTIVE.
REQ-040 Return pulse at o_credits=CREDITS -> o_credit_err 1 for one cycle, count unchanged; reset asserted mid-packet -> all REQ-032 values within same cycle.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types for the router output-port logic: port FSM states, port status
// encoding and the default flit width.
package router_pkg;

    localparam int FLIT_W_DEF = 34;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        BLOCKED = 2'd2
    } port_state_t;

    typedef enum logic {
        PORT_FREE     = 1'b0,
        PORT_OCCUPIED = 1'b1
    } PORT_STATUS_t;

endpackage

// File: rtl/output_port_ctrl_if.sv
// Input-unit / downstream-link signal bundle of one router output port.
// slave is the port controller's view, master is the driver's view.
interface output_port_ctrl_if
    import router_pkg::*;
#(
    parameter int NUM_IN = 5,
    parameter int FLIT_W = FLIT_W_DEF
);
    logic [NUM_IN-1:0]             i_req;
    logic [NUM_IN-1:0]             o_grant;
    logic [NUM_IN-1:0]             i_valid;
    logic [NUM_IN-1:0]             i_tail;
    logic [NUM_IN-1:0][FLIT_W-1:0] i_data;
    logic [NUM_IN-1:0]             o_ready;
    logic                          o_valid;
    logic [FLIT_W-1:0]             o_data;
    logic                          o_tail;
    logic                          i_credit_return;

    modport slave (
        input  i_req, i_valid, i_tail, i_data, i_credit_return,
        output o_grant, o_ready, o_valid, o_data, o_tail
    );

    modport master (
        output i_req, i_valid, i_tail, i_data, i_credit_return,
        input  o_grant, o_ready, o_valid, o_data, o_tail
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from ptr; ptr moves
// past the winner only when en is set and some request was granted.
module rr_arbiter #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] cand;
    logic [PW-1:0] sel;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = PW'((int'(ptr_q) + i) % N);
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                sel         = cand;
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en && found) ptr_d = (sel == PW'(N - 1)) ? '0 : sel + PW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
endmodule

// File: rtl/output_port_ctrl.sv
// Router output-port controller: arbitrates input units for packet ownership,
// forwards the owner's flits one cycle later and tracks downstream credits.
module output_port_ctrl
    import router_pkg::*;
#(
    parameter  int NUM_IN  = 5,
    parameter  int FLIT_W  = FLIT_W_DEF,
    parameter  int CREDITS = 4,
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output_port_ctrl_if.slave     bus,
    output logic [CW-1:0]         o_credits,
    output logic                  o_port_status,
    output logic [1:0]            o_state,
    output logic                  o_credit_err
);
    port_state_t       state_q, state_d;
    logic [NUM_IN-1:0] grant_q, grant_d;
    logic [CW-1:0]     credits_q, credits_d;
    logic              valid_q, valid_d;
    logic [FLIT_W-1:0] data_q, data_d;
    logic              tail_q, tail_d;
    logic              err_q, err_d;

    logic [NUM_IN-1:0] arb_grant;
    logic              arb_en;
    logic              owner_valid, owner_tail;
    logic [FLIT_W-1:0] owner_data;
    logic              fire;

    assign arb_en = (state_q == IDLE);

    rr_arbiter #(.N(NUM_IN)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.i_req),
        .en      (arb_en),
        .grant   (arb_grant)
    );

    // grant_q is one-hot (or zero), so an AND-OR mux selects the owner's flit.
    always_comb begin
        owner_valid = |(bus.i_valid & grant_q);
        owner_tail  = |(bus.i_tail & grant_q);
        owner_data  = '0;
        for (int k = 0; k < NUM_IN; k++)
            if (grant_q[k]) owner_data = owner_data | bus.i_data[k];
    end

    assign fire        = (state_q == ACTIVE) && owner_valid && (credits_q != '0);
    assign bus.o_ready = {NUM_IN{fire}} & grant_q;

    always_comb begin
        credits_d = credits_q;
        err_d     = 1'b0;
        unique case ({fire, bus.i_credit_return})
            2'b10: credits_d = credits_q - CW'(1);
            2'b01: begin
                if (credits_q == CW'(CREDITS)) err_d = 1'b1;
                else                           credits_d = credits_q + CW'(1);
            end
            default: ;
        endcase
    end

    // Tail check precedes the credit check so a tail on the last credit frees the port.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.i_req) begin
                    state_d = ACTIVE;
                    grant_d = arb_grant;
                end
            end
            ACTIVE: begin
                if (fire && owner_tail) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (credits_d == '0) begin
                    state_d = BLOCKED;
                end
            end
            BLOCKED: begin
                if (bus.i_credit_return) state_d = ACTIVE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        valid_d = fire;
        data_d  = fire ? owner_data : data_q;
        tail_d  = fire ? owner_tail : tail_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            credits_q <= CW'(CREDITS);
            valid_q   <= 1'b0;
            data_q    <= '0;
            tail_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            credits_q <= credits_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            tail_q    <= tail_d;
            err_q     <= err_d;
        end
    end

    assign bus.o_grant   = grant_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_data    = data_q;
    assign bus.o_tail    = tail_q;
    assign o_credits     = credits_q;
    assign o_credit_err  = err_q;
    assign o_state       = state_q;
    assign o_port_status = (state_q == IDLE) ? PORT_FREE : PORT_OCCUPIED;
endmodule

// File: tb/tb_output_port_ctrl.sv
// Bench for output_port_ctrl: two instances (CREDITS=4 and CREDITS=2) fed by
// per-input flit queues; accepted flits go to a scoreboard checked against link beats.
module tb_output_port_ctrl;
    import router_pkg::*;

    localparam int NI = 5;
    localparam int FW = 34;

    typedef struct packed {
        logic [FW-1:0] data;
        logic          tail;
        int            cyc;
    } flit_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    output_port_ctrl_if #(.NUM_IN(NI), .FLIT_W(FW)) ifa ();
    output_port_ctrl_if #(.NUM_IN(NI), .FLIT_W(FW)) ifb ();

    logic [2:0] cred_a;
    logic [1:0] cred_b;
    logic       stat_a, stat_b, err_a, err_b;
    logic [1:0] st_a, st_b;

    output_port_ctrl #(.NUM_IN(NI), .FLIT_W(FW), .CREDITS(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa), .o_credits(cred_a),
        .o_port_status(stat_a), .o_state(st_a), .o_credit_err(err_a)
    );

    output_port_ctrl #(.NUM_IN(NI), .FLIT_W(FW), .CREDITS(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb), .o_credits(cred_b),
        .o_port_status(stat_b), .o_state(st_b), .o_credit_err(err_b)
    );

    flit_t pend_a [NI][$];
    flit_t pend_b [NI][$];
    flit_t exp_a[$], exp_b[$], obs_a[$], obs_b[$];
    int    cyc, errors, checks, multi_ready;

    function automatic void drive();
        for (int k = 0; k < NI; k++) begin
            ifa.i_valid[k] = pend_a[k].size() > 0;
            ifa.i_data[k]  = (pend_a[k].size() > 0) ? pend_a[k][0].data : '0;
            ifa.i_tail[k]  = (pend_a[k].size() > 0) ? pend_a[k][0].tail : 1'b0;
            ifb.i_valid[k] = pend_b[k].size() > 0;
            ifb.i_data[k]  = (pend_b[k].size() > 0) ? pend_b[k][0].data : '0;
            ifb.i_tail[k]  = (pend_b[k].size() > 0) ? pend_b[k][0].tail : 1'b0;
        end
    endfunction

    function automatic void load_pkt(bit on_b, int k, int n, int tag);
        flit_t f;
        for (int i = 0; i < n; i++) begin
            f.data = FW'(tag * 256 + i);
            f.tail = (i == n - 1);
            f.cyc  = 0;
            if (on_b) pend_b[k].push_back(f);
            else      pend_a[k].push_back(f);
        end
    endfunction

    function automatic int oh_idx(logic [NI-1:0] v);
        for (int i = 0; i < NI; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic void clear_all();
        for (int k = 0; k < NI; k++) begin
            pend_a[k].delete();
            pend_b[k].delete();
        end
        exp_a.delete(); exp_b.delete(); obs_a.delete(); obs_b.delete();
        ifa.i_req = '0; ifb.i_req = '0;
        ifa.i_credit_return = 1'b0; ifb.i_credit_return = 1'b0;
        drive();
    endfunction

    // One clock: sample pops and link beats mid-cycle, then advance the input queues.
    task automatic tick();
        logic [NI-1:0] ra, rb;
        flit_t f;
        @(negedge clk);
        ra = ifa.o_ready;
        rb = ifb.o_ready;
        if (!$onehot0(ra) || !$onehot0(rb) || !$onehot0(ifa.o_grant) || !$onehot0(ifb.o_grant))
            multi_ready++;
        if (ifa.o_valid) begin
            f.data = ifa.o_data; f.tail = ifa.o_tail; f.cyc = cyc;
            obs_a.push_back(f);
        end
        if (ifb.o_valid) begin
            f.data = ifb.o_data; f.tail = ifb.o_tail; f.cyc = cyc;
            obs_b.push_back(f);
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int k = 0; k < NI; k++) begin
            if (ra[k] && pend_a[k].size() > 0) begin
                f = pend_a[k].pop_front(); f.cyc = cyc; exp_a.push_back(f);
            end
            if (rb[k] && pend_b[k].size() > 0) begin
                f = pend_b[k].pop_front(); f.cyc = cyc; exp_b.push_back(f);
            end
        end
        drive();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({st_a, ifa.o_grant, cred_a, ifa.o_valid, ifa.o_data, ifa.o_tail, err_a, stat_a} !==
            {2'd0, 5'd0, 3'd4, 1'b0, 34'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_a: st=%0d grant=%b cred=%0d v=%b d=%h t=%b err=%b stat=%b want st=0 grant=0 cred=4 rest 0",
                     st_a, ifa.o_grant, cred_a, ifa.o_valid, ifa.o_data, ifa.o_tail, err_a, stat_a);
        end
        checks++;
        if ({st_b, ifb.o_grant, cred_b, ifb.o_valid, ifb.o_data, ifb.o_tail, err_b, stat_b} !==
            {2'd0, 5'd0, 2'd2, 1'b0, 34'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_b: st=%0d grant=%b cred=%0d v=%b d=%h t=%b err=%b stat=%b want st=0 grant=0 cred=2 rest 0",
                     st_b, ifb.o_grant, cred_b, ifb.o_valid, ifb.o_data, ifb.o_tail, err_b, stat_b);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(); tick();
        checks++;
        if ({st_a, cred_a, ifa.o_valid} !== {2'd0, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL idle_after_reset: st=%0d cred=%0d v=%b want 0 4 0", st_a, cred_a, ifa.o_valid);
        end
    endtask

    task automatic test_single_packet();
        int n;
        flit_t e, o;
        ifa.i_req[2] = 1'b1;
        load_pkt(0, 2, 3, 8'h21);
        drive();
        tick();
        checks++;
        if (ifa.o_grant !== 5'b00100 || st_a !== 2'd1 || stat_a !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: grant=%b st=%0d stat=%b want 00100 1 1", ifa.o_grant, st_a, stat_a);
        end
        ifa.i_req[2] = 1'b0;
        n = 0;
        while (st_a != 2'd0 && n < 20) begin tick(); n++; end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL single_cycles: got %0d cycles to IDLE want 3", n);
        end
        tick();
        checks++;
        if (cred_a !== 3'd1 || ifa.o_grant !== 5'd0) begin
            errors++;
            $display("FAIL single_credits: cred=%0d grant=%b want 1 00000", cred_a, ifa.o_grant);
        end
        checks++;
        if (obs_a.size() != 3 || exp_a.size() != 3) begin
            errors++;
            $display("FAIL single_count: beats=%0d accepted=%0d want 3 3", obs_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single_flit: got d=%h t=%b cyc=%0d want d=%h t=%b cyc=%0d", o.data, o.tail, o.cyc, e.data, e.tail, e.cyc);
            end
        end
        ifa.i_credit_return = 1'b1;
        repeat (3) tick();
        ifa.i_credit_return = 1'b0;
        tick();
        checks++;
        if (cred_a !== 3'd4 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL single_refill: cred=%0d err=%b want 4 0", cred_a, err_a);
        end
    endtask

    task automatic test_round_robin();
        int gseq[$], gcyc[$], want[4], n;
        logic [NI-1:0] prev;
        flit_t e, o;
        want = '{0, 1, 3, 0};
        do_reset();
        for (int j = 0; j < 3; j++) begin
            n = (j == 2) ? 3 : j;
            load_pkt(0, n, 1, n * 16);
            load_pkt(0, n, 1, n * 16 + 1);
            ifa.i_req[n] = 1'b1;
        end
        drive();
        prev = '0;
        n = 0;
        while (gseq.size() < 4 && n < 40) begin
            tick(); n++;
            if (ifa.o_grant != '0 && prev == '0) begin
                gseq.push_back(oh_idx(ifa.o_grant));
                gcyc.push_back(cyc);
            end
            prev = ifa.o_grant;
        end
        ifa.i_req = '0;
        repeat (3) tick();
        checks++;
        if (gseq.size() != 4) begin
            errors++;
            $display("FAIL rr_grants: got %0d grants want 4", gseq.size());
        end
        for (int i = 0; i < gseq.size() && i < 4; i++) begin
            checks++;
            if (gseq[i] != want[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got input %0d want %0d", i, gseq[i], want[i]);
            end
            if (i > 0) begin
                checks++;
                if (gcyc[i] - gcyc[i-1] != 2) begin
                    errors++;
                    $display("FAIL rr_bubble[%0d]: got spacing %0d want 2", i, gcyc[i] - gcyc[i-1]);
                end
            end
        end
        checks++;
        if (cred_a !== 3'd0 || st_a !== 2'd0) begin
            errors++;
            $display("FAIL rr_tail_last_credit: cred=%0d st=%0d want 0 0", cred_a, st_a);
        end
        checks++;
        if (obs_a.size() != 4) begin
            errors++;
            $display("FAIL rr_count: beats=%0d want 4", obs_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rr_flit: got d=%h t=%b cyc=%0d want d=%h t=%b cyc=%0d", o.data, o.tail, o.cyc, e.data, e.tail, e.cyc);
            end
        end
    endtask

    task automatic test_blocked();
        flit_t e, o;
        do_reset();
        ifb.i_req[4] = 1'b1;
        load_pkt(1, 4, 5, 8'h40);
        drive();
        tick();
        ifb.i_req[4] = 1'b0;
        checks++;
        if (ifb.o_grant !== 5'b10000) begin
            errors++;
            $display("FAIL blk_grant: got %b want 10000", ifb.o_grant);
        end
        repeat (8) tick();
        checks++;
        if (obs_b.size() != 2 || st_b !== 2'd2 || ifb.o_ready !== 5'd0 || cred_b !== 2'd0 || ifb.o_grant !== 5'b10000) begin
            errors++;
            $display("FAIL blk_stall: beats=%0d st=%0d ready=%b cred=%0d grant=%b want 2 2 00000 0 10000",
                     obs_b.size(), st_b, ifb.o_ready, cred_b, ifb.o_grant);
        end
        ifb.i_credit_return = 1'b1;
        tick();
        ifb.i_credit_return = 1'b0;
        checks++;
        if (st_b !== 2'd1 || cred_b !== 2'd1) begin
            errors++;
            $display("FAIL blk_resume: st=%0d cred=%0d want 1 1", st_b, cred_b);
        end
        repeat (6) tick();
        checks++;
        if (obs_b.size() != 3 || st_b !== 2'd2 || cred_b !== 2'd0 || ifb.o_ready !== 5'd0) begin
            errors++;
            $display("FAIL blk_one_more: beats=%0d st=%0d cred=%0d ready=%b want 3 2 0 00000",
                     obs_b.size(), st_b, cred_b, ifb.o_ready);
        end
        while (exp_b.size() > 0 && obs_b.size() > 0) begin
            e = exp_b.pop_front(); o = obs_b.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL blk_flit: got d=%h t=%b cyc=%0d want d=%h t=%b cyc=%0d", o.data, o.tail, o.cyc, e.data, e.tail, e.cyc);
            end
        end
    endtask

    task automatic test_fire_and_return();
        int n;
        do_reset();
        ifa.i_req[1] = 1'b1;
        load_pkt(0, 1, 6, 8'h11);
        drive();
        tick();
        ifa.i_req[1] = 1'b0;
        n = 0;
        while (cred_a != 3'd1 && n < 10) begin tick(); n++; end
        checks++;
        if (n != 3 || st_a !== 2'd1) begin
            errors++;
            $display("FAIL far_setup: cycles=%0d st=%0d want 3 1", n, st_a);
        end
        ifa.i_credit_return = 1'b1;
        tick();
        ifa.i_credit_return = 1'b0;
        checks++;
        if (cred_a !== 3'd1 || st_a !== 2'd1) begin
            errors++;
            $display("FAIL far_same_cycle: cred=%0d st=%0d want 1 1", cred_a, st_a);
        end
        tick();
        checks++;
        if (obs_a.size() != 4 || cred_a !== 3'd0 || st_a !== 2'd2) begin
            errors++;
            $display("FAIL far_after: beats=%0d cred=%0d st=%0d want 4 0 2", obs_a.size(), cred_a, st_a);
        end
    endtask

    task automatic test_credit_err();
        do_reset();
        ifa.i_credit_return = 1'b1;
        tick();
        ifa.i_credit_return = 1'b0;
        checks++;
        if (err_a !== 1'b1 || cred_a !== 3'd4) begin
            errors++;
            $display("FAIL cerr_pulse: err=%b cred=%0d want 1 4", err_a, cred_a);
        end
        tick();
        checks++;
        if (err_a !== 1'b0 || cred_a !== 3'd4) begin
            errors++;
            $display("FAIL cerr_clear: err=%b cred=%0d want 0 4", err_a, cred_a);
        end
    endtask

    task automatic test_reset_mid_packet();
        flit_t e, o;
        do_reset();
        ifa.i_req[3] = 1'b1;
        load_pkt(0, 3, 5, 8'h33);
        drive();
        tick();
        ifa.i_req[3] = 1'b0;
        tick(); tick();
        checks++;
        if (ifa.o_valid !== 1'b1 || cred_a !== 3'd2) begin
            errors++;
            $display("FAIL mid_setup: v=%b cred=%0d want 1 2", ifa.o_valid, cred_a);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({st_a, ifa.o_grant, cred_a, ifa.o_valid, ifa.o_data, ifa.o_tail, err_a, stat_a, ifa.o_ready} !==
            {2'd0, 5'd0, 3'd4, 1'b0, 34'd0, 1'b0, 1'b0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL mid_reset: st=%0d grant=%b cred=%0d v=%b d=%h t=%b err=%b stat=%b rdy=%b want st=0 cred=4 rest 0",
                     st_a, ifa.o_grant, cred_a, ifa.o_valid, ifa.o_data, ifa.o_tail, err_a, stat_a, ifa.o_ready);
        end
        exp_a.delete(); obs_a.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) tick();
        checks++;
        if (obs_a.size() != 0 || ifa.o_grant !== 5'd0) begin
            errors++;
            $display("FAIL mid_abandon: beats=%0d grant=%b want 0 00000", obs_a.size(), ifa.o_grant);
        end
        ifa.i_req = 5'b10010;
        load_pkt(0, 1, 1, 8'h51);
        load_pkt(0, 4, 1, 8'h54);
        drive();
        tick();
        ifa.i_req = '0;
        checks++;
        if (ifa.o_grant !== 5'b00010) begin
            errors++;
            $display("FAIL mid_ptr_reset: grant=%b want 00010", ifa.o_grant);
        end
        repeat (3) tick();
        checks++;
        if (obs_a.size() != 1) begin
            errors++;
            $display("FAIL mid_fresh_count: beats=%0d want 1", obs_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front();
            checks++;
            if (o !== e || o.data !== 34'h5100) begin
                errors++;
                $display("FAIL mid_fresh_flit: got d=%h cyc=%0d want d=%h cyc=%0d", o.data, o.cyc, 34'h5100, e.cyc);
            end
        end
        checks++;
        if (multi_ready != 0) begin
            errors++;
            $display("FAIL onehot: %0d cycles with multi-hot ready/grant want 0", multi_ready);
        end
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; multi_ready = 0;
        reset_n = 1'b1;
        clear_all();
        test_reset();
        test_single_packet();
        test_round_robin();
        test_blocked();
        test_fire_and_return();
        test_credit_err();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
